// File: rtl/datamem_responder.sv
// datamem_responder
//
// Memory-side responder for the CPU data-memory port. Accepts one load or
// store per handshake, holds it for LATENCY cycles and then answers with a
// one-cycle response strobe carrying read data or an error flag. Storage is
// an internal byte-addressed, little-endian array that reset does not touch.
//
// Ports:
//   clk          rising-edge clock for all state
//   reset        synchronous, active-high
//   req_valid    initiator presents a request
//   req_ready    responder is idle and can take a request this cycle
//   address      byte address of the access
//   write_enable request is a store
//   read_enable  request is a load
//   write_data   store data, right-justified (low xfer_size bytes used)
//   xfer_size    access width in bytes (1, 2, 4 or 8 are legal)
//   resp_valid   one-cycle response strobe
//   read_data    zero-extended load result, held until the next load response
//   error        request was rejected, qualified by resp_valid
module datamem_responder #(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] address,
    input  logic        write_enable,
    input  logic        read_enable,
    input  logic [63:0] write_data,
    input  logic [3:0]  xfer_size,
    output logic        resp_valid,
    output logic [63:0] read_data,
    output logic        error
);

    localparam int Depth = 1 << ADDR_BITS;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [3:0]  size_q, size_d;
    logic        we_q, we_d;
    logic        re_q, re_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [7:0]  mem_q [Depth];

    logic [63:0]          effAddr;
    logic [63:0]          effWdata;
    logic [3:0]           effSize;
    logic                 effWe;
    logic                 effRe;
    logic [ADDR_BITS-1:0] memIdx;
    logic                 sizeOk;
    logic                 misaligned;
    logic                 outOfRange;
    logic                 reqError;
    logic [63:0]          loadData;
    logic                 enterResp;
    logic                 memWrite;

    // The request being resolved: with LATENCY=1 the response is produced on
    // the same edge that accepts the request, so in IDLE the live inputs are
    // used; in every other state the latched copy is used.
    always_comb begin
        if (state_q == IDLE) begin
            effAddr  = address;
            effWdata = write_data;
            effSize  = xfer_size;
            effWe    = write_enable;
            effRe    = read_enable;
        end else begin
            effAddr  = addr_q;
            effWdata = wdata_q;
            effSize  = size_q;
            effWe    = we_q;
            effRe    = re_q;
        end
    end

    // Error classification and the little-endian gather of the load bytes.
    // The alignment mask is only meaningful for legal sizes, which the size
    // check already covers.
    always_comb begin
        memIdx     = effAddr[ADDR_BITS-1:0];
        sizeOk     = (effSize == 4'd1) || (effSize == 4'd2) ||
                     (effSize == 4'd4) || (effSize == 4'd8);
        misaligned = |(effAddr[3:0] & (effSize - 4'd1));
        outOfRange = |effAddr[63:ADDR_BITS];
        reqError   = (effWe & effRe) | ~sizeOk | misaligned | outOfRange;
        loadData   = '0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < effSize) begin
                loadData[8*i +: 8] = mem_q[memIdx + ADDR_BITS'(i)];
            end
        end
    end

    // Next-state logic. The counter is loaded with LATENCY-1 on accept and
    // BUSY hands over to RESP on the edge where it decrements to zero.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        size_d    = size_q;
        we_d      = we_q;
        re_d      = re_q;
        rdata_d   = rdata_q;
        err_d     = 1'b0;
        enterResp = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && (write_enable || read_enable)) begin
                    addr_d  = address;
                    wdata_d = write_data;
                    size_d  = xfer_size;
                    we_d    = write_enable;
                    re_d    = read_enable;
                    cnt_d   = 4'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_d   = RESP;
                        enterResp = 1'b1;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d   = RESP;
                    enterResp = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (enterResp) begin
            err_d = reqError;
            if (reqError) begin
                rdata_d = '0;
            end else if (effRe) begin
                rdata_d = loadData;
            end
        end
    end

    // A store commits on the RESP-entry edge unless a reset lands on that
    // same edge, in which case the request is dropped entirely.
    assign memWrite = enterResp && !reqError && effWe && !reset;

    // State and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            we_q    <= we_d;
            re_q    <= re_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Byte array, deliberately outside reset.
    always_ff @(posedge clk) begin
        if (memWrite) begin
            for (int i = 0; i < 8; i++) begin
                if (4'(i) < effSize) begin
                    mem_q[memIdx + ADDR_BITS'(i)] <= effWdata[8*i +: 8];
                end
            end
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign read_data  = rdata_q;
    assign error      = err_q;

endmodule

// File: tb/tb_datamem_responder.sv
// tb_datamem_responder
//
// Directed bench for datamem_responder. Instance dutA uses LATENCY=2 and
// dutB uses LATENCY=1; both share clock and reset. Inputs change on the
// falling edge and outputs are sampled on the falling edge.
module tb_datamem_responder;

    logic        clk = 1'b0;
    logic        reset;

    logic        aValid, aReady, aWe, aRe, aRespValid, aErr;
    logic [63:0] aAddr, aWdata, aRdata;
    logic [3:0]  aSize;

    logic        bValid, bReady, bWe, bRe, bRespValid, bErr;
    logic [63:0] bAddr, bWdata, bRdata;
    logic [3:0]  bSize;

    int total = 0;
    int bad   = 0;

    datamem_responder #(.ADDR_BITS(10), .LATENCY(2)) dutA (
        .clk(clk), .reset(reset),
        .req_valid(aValid), .req_ready(aReady),
        .address(aAddr), .write_enable(aWe), .read_enable(aRe),
        .write_data(aWdata), .xfer_size(aSize),
        .resp_valid(aRespValid), .read_data(aRdata), .error(aErr)
    );

    datamem_responder #(.ADDR_BITS(10), .LATENCY(1)) dutB (
        .clk(clk), .reset(reset),
        .req_valid(bValid), .req_ready(bReady),
        .address(bAddr), .write_enable(bWe), .read_enable(bRe),
        .write_data(bWdata), .xfer_size(bSize),
        .resp_valid(bRespValid), .read_data(bRdata), .error(bErr)
    );

    always #5 clk = ~clk;

    // Drive the request inputs of one instance.
    task automatic drive(input bit useB, input logic v, input logic we, input logic re,
                         input logic [63:0] addr, input logic [63:0] wd, input logic [3:0] sz);
        if (useB) begin
            bValid = v; bWe = we; bRe = re; bAddr = addr; bWdata = wd; bSize = sz;
        end else begin
            aValid = v; aWe = we; aRe = re; aAddr = addr; aWdata = wd; aSize = sz;
        end
    endtask

    // One request; returns the response and the number of falling edges from
    // the accept edge to the response (equals LATENCY), or -1 on timeout.
    task automatic transact(input bit useB, input logic we, input logic re,
                            input logic [63:0] addr, input logic [63:0] wd, input logic [3:0] sz,
                            output logic [63:0] rd, output logic err, output int lat);
        @(negedge clk);
        drive(useB, 1'b1, we, re, addr, wd, sz);
        @(posedge clk);
        #1;
        drive(useB, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 4'h0);
        lat = -1;
        rd  = '0;
        err = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (useB ? bRespValid : aRespValid) begin
                lat = k;
                rd  = useB ? bRdata : aRdata;
                err = useB ? bErr : aErr;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 4'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 4'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        total++; if (aReady !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", aReady); end
        total++; if (aRespValid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b want=0", aRespValid); end
        total++; if (aErr !== 1'b0) begin bad++; $display("FAIL reset_error got=%b want=0", aErr); end
        total++; if (aRdata !== 64'h0) begin bad++; $display("FAIL reset_read_data got=%h want=0", aRdata); end
        total++; if (bReady !== 1'b1) begin bad++; $display("FAIL reset_ready_b got=%b want=1", bReady); end
    endtask

    task automatic test_store_load();
        logic [63:0] rd; logic err; int lat;
        transact(1'b0, 1'b1, 1'b0, 64'h10, 64'h1122334455667788, 4'd8, rd, err, lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL store_latency got=%0d want=2", lat); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL store_error got=%b want=0", err); end
        total++; if (rd !== 64'h0) begin bad++; $display("FAIL store_keeps_rdata got=%h want=0", rd); end
        @(negedge clk);
        total++; if (aRespValid !== 1'b0) begin bad++; $display("FAIL resp_one_cycle got=%b want=0", aRespValid); end
        transact(1'b0, 1'b0, 1'b1, 64'h10, 64'h0, 4'd8, rd, err, lat);
        total++; if (rd !== 64'h1122334455667788) begin bad++; $display("FAIL load8 got=%h want=1122334455667788", rd); end
        total++; if (lat !== 2) begin bad++; $display("FAIL load_latency got=%0d want=2", lat); end
    endtask

    task automatic test_lanes();
        logic [63:0] rd; logic err; int lat;
        logic [63:0] addrs [3] = '{64'h10, 64'h12, 64'h14};
        logic [3:0]  sizes [3] = '{4'd1, 4'd2, 4'd4};
        logic [63:0] exps  [3] = '{64'h88, 64'h5566, 64'h11223344};
        for (int i = 0; i < 3; i++) begin
            transact(1'b0, 1'b0, 1'b1, addrs[i], 64'h0, sizes[i], rd, err, lat);
            total++; if (rd !== exps[i] || err !== 1'b0) begin
                bad++; $display("FAIL lane_load%0d got=%h err=%b want=%h err=0", i, rd, err, exps[i]);
            end
        end
        transact(1'b0, 1'b1, 1'b0, 64'h11, 64'hFFFF_FFFF_FFFF_FFAB, 4'd1, rd, err, lat);
        total++; if (rd !== 64'h11223344 || err !== 1'b0) begin
            bad++; $display("FAIL byte_store got=%h err=%b want=11223344 err=0", rd, err);
        end
        transact(1'b0, 1'b0, 1'b1, 64'h10, 64'h0, 4'd8, rd, err, lat);
        total++; if (rd !== 64'h112233445566AB88) begin bad++; $display("FAIL merged_load got=%h want=112233445566ab88", rd); end
    endtask

    task automatic test_errors();
        logic [63:0] rd; logic err; int lat;
        logic        wes   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [63:0] addrs [4] = '{64'h12, 64'h10, 64'h400, 64'h10};
        logic [3:0]  sizes [4] = '{4'd4, 4'd3, 4'd8, 4'd8};
        for (int i = 0; i < 4; i++) begin
            transact(1'b0, wes[i], 1'b1, addrs[i], 64'hFFFF_FFFF_FFFF_FFFF, sizes[i], rd, err, lat);
            total++; if (err !== 1'b1 || rd !== 64'h0 || lat !== 2) begin
                bad++; $display("FAIL error_case%0d got err=%b rd=%h lat=%0d want err=1 rd=0 lat=2", i, err, rd, lat);
            end
            transact(1'b0, 1'b0, 1'b1, 64'h10, 64'h0, 4'd8, rd, err, lat);
            total++; if (rd !== 64'h112233445566AB88 || err !== 1'b0) begin
                bad++; $display("FAIL error_case%0d_intact got=%h err=%b want=112233445566ab88 err=0", i, rd, err);
            end
        end
    endtask

    // req_valid held high with alternating single-byte loads; checks the
    // accept spacing, the number of accepts and the data of each response.
    task automatic test_back_to_back(input bit useB, input int cycles, input int period,
                                     input int wantAccepts, input logic [63:0] addr0,
                                     input logic [63:0] addr1, input logic [63:0] exp0,
                                     input logic [63:0] exp1);
        int accepts = 0;
        int resps   = 0;
        int lastAcc = -1;
        logic [63:0] want;
        @(negedge clk);
        drive(useB, 1'b1, 1'b0, 1'b1, addr0, 64'h0, 4'd1);
        for (int i = 0; i < cycles; i++) begin
            if (i > 0) @(negedge clk);
            if (useB ? bRespValid : aRespValid) begin
                want = (resps % 2 == 1) ? exp1 : exp0;
                total++; if ((useB ? bRdata : aRdata) !== want) begin
                    bad++; $display("FAIL b2b_data%0d got=%h want=%h", resps, useB ? bRdata : aRdata, want);
                end
                resps++;
            end
            if (useB ? bReady : aReady) begin
                if (lastAcc >= 0) begin
                    total++; if (i - lastAcc !== period) begin
                        bad++; $display("FAIL b2b_period got=%0d want=%0d", i - lastAcc, period);
                    end
                end
                drive(useB, 1'b1, 1'b0, 1'b1, (accepts % 2 == 1) ? addr1 : addr0, 64'h0, 4'd1);
                lastAcc = i;
                accepts++;
            end
        end
        drive(useB, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 4'h0);
        total++; if (accepts !== wantAccepts) begin bad++; $display("FAIL b2b_accepts got=%0d want=%0d", accepts, wantAccepts); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_no_enable();
        int seen = 0;
        int notReady = 0;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 64'h10, 64'h0, 4'd8);
        repeat (20) begin
            @(negedge clk);
            if (aRespValid) seen++;
            if (!aReady) notReady++;
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 4'h0);
        total++; if (seen !== 0) begin bad++; $display("FAIL no_enable_resp got=%0d want=0", seen); end
        total++; if (notReady !== 0) begin bad++; $display("FAIL no_enable_ready got=%0d want=0", notReady); end
    endtask

    task automatic test_reset_midop();
        logic [63:0] rd; logic err; int lat;
        int seen = 0;
        transact(1'b0, 1'b1, 1'b0, 64'h20, 64'h1234, 4'd2, rd, err, lat);
        total++; if (err !== 1'b0 || lat !== 2) begin bad++; $display("FAIL midop_prestore err=%b lat=%0d want err=0 lat=2", err, lat); end
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 64'h20, 64'hDEAD, 4'd2);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 4'h0);
        @(negedge clk);
        total++; if (aReady !== 1'b0) begin bad++; $display("FAIL midop_busy got=%b want=0", aReady); end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        total++; if (aReady !== 1'b1) begin bad++; $display("FAIL midop_ready got=%b want=1", aReady); end
        if (aRespValid) seen++;
        repeat (5) begin
            @(negedge clk);
            if (aRespValid) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL midop_resp got=%0d want=0", seen); end
        transact(1'b0, 1'b0, 1'b1, 64'h20, 64'h0, 4'd2, rd, err, lat);
        total++; if (rd !== 64'h1234) begin bad++; $display("FAIL midop_load got=%h want=1234", rd); end
    endtask

    task automatic test_latency1();
        logic [63:0] rd; logic err; int lat;
        transact(1'b1, 1'b1, 1'b0, 64'h8, 64'hCAFEBABE, 4'd4, rd, err, lat);
        total++; if (lat !== 1 || err !== 1'b0) begin bad++; $display("FAIL l1_store lat=%0d err=%b want lat=1 err=0", lat, err); end
        transact(1'b1, 1'b0, 1'b1, 64'h8, 64'h0, 4'd4, rd, err, lat);
        total++; if (lat !== 1) begin bad++; $display("FAIL l1_latency got=%0d want=1", lat); end
        total++; if (rd !== 64'hCAFEBABE) begin bad++; $display("FAIL l1_load got=%h want=cafebabe", rd); end
        test_back_to_back(1'b1, 8, 2, 4, 64'h8, 64'h9, 64'hBE, 64'hBA);
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_lanes();
        test_errors();
        test_back_to_back(1'b0, 12, 3, 4, 64'h10, 64'h11, 64'h88, 64'hAB);
        test_no_enable();
        test_reset_midop();
        test_latency1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
